// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the bitmap VRAM arbiter: default geometry and host FSM encoding.
package vram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 11;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned STARVE_LIMIT_DEF = 1024;

  // Display raster is 128x128; coordinates are 7 bits.
  localparam int unsigned DISP_W  = 128;
  localparam int unsigned COORD_W = 7;

  typedef enum logic [1:0] {
    H_IDLE    = 2'd0,
    H_RD_WAIT = 2'd1,
    H_RD_CAP  = 2'd2
  } host_state_e;

endpackage

// File: rtl/vram_disp_fetch.sv
// Display side of the arbiter: pixel-to-word address and the two-stage
// bit-select/valid pipeline that lines up with the one-cycle RAM read.
module vram_disp_fetch
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [ADDR_W-1:0]  disp_addr_c,
  output logic               disp_pix,
  output logic               disp_pix_valid
);

  localparam int unsigned BIT_W         = $clog2(DATA_W);
  localparam int unsigned WORDS_PER_ROW = DISP_W / DATA_W;

  logic [BIT_W-1:0] bit_s1;
  logic [BIT_W-1:0] bit_s2;
  logic             vld_s1;
  logic             vld_s2;

  // Row-major word address; the low column bits select the pixel inside the word.
  assign disp_addr_c = ADDR_W'(disp_y) * ADDR_W'(WORDS_PER_ROW)
                     + ADDR_W'(disp_x[COORD_W-1:BIT_W]);

  // Stage 1/2 carry the bit index (stored inverted so MSB is leftmost pixel) and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_s1         <= '0;
      bit_s2         <= '0;
      vld_s1         <= 1'b0;
      vld_s2         <= 1'b0;
      disp_pix       <= 1'b0;
      disp_pix_valid <= 1'b0;
    end else begin
      bit_s1         <= disp_req ? ~disp_x[BIT_W-1:0] : '0;
      vld_s1         <= disp_req;
      bit_s2         <= bit_s1;
      vld_s2         <= vld_s1;
      disp_pix       <= vld_s2 & ram_rdata[bit_s2];
      disp_pix_valid <= vld_s2;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port bitmap VRAM arbiter: display fetch always wins the port,
// the host gets idle cycles through a small read/write FSM with a starvation flag.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  output logic               disp_pix,
  output logic               disp_pix_valid,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_ack,
  output logic [DATA_W-1:0]  host_rdata,
  output logic               host_starve,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  localparam int unsigned    CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  host_state_e       state_q;
  host_state_e       state_d;
  logic              wr_pend_q;
  logic              wr_pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_we_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              host_ack_d;
  logic [DATA_W-1:0] host_rdata_d;
  logic              host_starve_d;
  logic              host_busy_c;
  logic              grant_c;
  logic [ADDR_W-1:0] disp_addr_c;

  vram_disp_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_disp_fetch (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_req       (disp_req),
    .disp_x         (disp_x),
    .disp_y         (disp_y),
    .ram_rdata      (ram_rdata),
    .disp_addr_c    (disp_addr_c),
    .disp_pix       (disp_pix),
    .disp_pix_valid (disp_pix_valid)
  );

  // Next state, RAM port mux, host handshake and wait counter.
  always_comb begin
    state_d       = state_q;
    wr_pend_d     = 1'b0;
    cnt_d         = cnt_q;
    ram_addr_d    = ram_addr;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata;
    host_ack_d    = 1'b0;
    host_rdata_d  = host_rdata;
    host_starve_d = 1'b0;

    // A host access is in flight from grant until its ack cycle has passed;
    // blocking through the ack cycle gives the host time to drop host_req.
    host_busy_c = wr_pend_q || host_ack || (state_q != H_IDLE);
    grant_c     = host_req && !disp_req && !host_busy_c;

    if (disp_req) begin
      ram_addr_d = disp_addr_c;
    end else if (grant_c) begin
      ram_addr_d = host_addr;
      if (host_we) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = host_wdata;
        wr_pend_d   = 1'b1;
      end else begin
        state_d = H_RD_WAIT;
      end
    end

    // Read data for the grant is on ram_rdata during H_RD_CAP, regardless of
    // which requester owns the port in that cycle.
    case (state_q)
      H_RD_WAIT: state_d = H_RD_CAP;
      H_RD_CAP: begin
        host_rdata_d = ram_rdata;
        host_ack_d   = 1'b1;
        state_d      = H_IDLE;
      end
      default: ;
    endcase

    if (wr_pend_q) begin
      host_ack_d = 1'b1;
    end

    // Counts only cycles where the host is actually waiting for the port.
    if (grant_c) begin
      cnt_d = '0;
    end else if (host_req && !host_busy_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    host_starve_d = (cnt_d == CNT_MAX);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= H_IDLE;
      wr_pend_q   <= 1'b0;
      cnt_q       <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      host_starve <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_pend_q   <= wr_pend_d;
      cnt_q       <= cnt_d;
      ram_addr    <= ram_addr_d;
      ram_we      <= ram_we_d;
      ram_wdata   <= ram_wdata_d;
      host_ack    <= host_ack_d;
      host_rdata  <= host_rdata_d;
      host_starve <= host_starve_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic
// checked against a word-array reference of the bitmap.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned LIMIT  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              disp_req = 1'b0;
  logic [6:0]        disp_x = '0;
  logic [6:0]        disp_y = '0;
  logic              disp_pix;
  logic              disp_pix_valid;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_starve;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              load_all = 1'b0;

  int checks = 0;
  int errors = 0;

  // Expected display output for samples one and two edges back.
  logic e1_v = 1'b0, e1_p = 1'b0, e2_v = 1'b0, e2_p = 1'b0;

  vram_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_req       (disp_req),
    .disp_x         (disp_x),
    .disp_y         (disp_y),
    .disp_pix       (disp_pix),
    .disp_pix_valid (disp_pix_valid),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .host_starve    (host_starve),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a bulk preload from the reference image.
  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic int unsigned addr_f(input int unsigned x, input int unsigned y);
    return y * 16 + x / 8;
  endfunction

  function automatic logic pix_f(input int unsigned x, input int unsigned y);
    logic [7:0] w;
    w = ref_mem[addr_f(x, y)];
    return w[7 - (x % 8)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    load_all = 1'b1;
    tick();
    load_all = 1'b0;
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    host_req = 1'b0;
    repeat (n) tick();
    e1_v = 1'b0; e1_p = 1'b0; e2_v = 1'b0; e2_p = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (ram_addr !== '0 || ram_we !== 1'b0 || ram_wdata !== '0 || host_ack !== 1'b0 ||
        host_rdata !== '0 || host_starve !== 1'b0 || disp_pix !== 1'b0 || disp_pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h we=%b wd=%h ack=%b rd=%h starve=%b pix=%b vld=%b, required all 0",
               ram_addr, ram_we, ram_wdata, host_ack, host_rdata, host_starve, disp_pix, disp_pix_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_disp_fetch();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_mem[33] = 8'b0100_0000;
    ref_mem[2047] = 8'h01;
    load_mem();
    disp_req = 1'b1; disp_x = 7'd9; disp_y = 7'd2;
    tick();
    checks++;
    if (ram_addr !== 11'd33 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL disp_addr_33: addr=%0d we=%b, required 33 / 0", ram_addr, ram_we);
    end
    // Boundary corners back-to-back: last pixel then first pixel.
    disp_x = 7'd127; disp_y = 7'd127;
    tick();
    checks++;
    if (disp_pix_valid !== 1'b0 || ram_addr !== 11'd2047) begin
      errors++;
      $display("FAIL disp_corner_max: vld=%b addr=%0d, required 0 / 2047", disp_pix_valid, ram_addr);
    end
    disp_x = 7'd0; disp_y = 7'd0;
    tick();
    checks++;
    if (disp_pix_valid !== 1'b1 || disp_pix !== 1'b1 || ram_addr !== 11'd0) begin
      errors++;
      $display("FAIL disp_pix_latency2: vld=%b pix=%b addr=%0d, required 1 / 1 / 0", disp_pix_valid, disp_pix, ram_addr);
    end
    disp_req = 1'b0;
    tick();
    checks++;
    if (disp_pix_valid !== 1'b1 || disp_pix !== 1'b1) begin
      errors++;
      $display("FAIL disp_pix_corner_max: vld=%b pix=%b, required 1 / 1", disp_pix_valid, disp_pix);
    end
    tick();
    checks++;
    if (disp_pix_valid !== 1'b1 || disp_pix !== 1'b0) begin
      errors++;
      $display("FAIL disp_pix_corner_min: vld=%b pix=%b, required 1 / 0", disp_pix_valid, disp_pix);
    end
    tick();
    checks++;
    if (disp_pix_valid !== 1'b0 || disp_pix !== 1'b0) begin
      errors++;
      $display("FAIL disp_idle_zero: vld=%b pix=%b, required 0 / 0", disp_pix_valid, disp_pix);
    end
    idle(2);
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h7FF; host_wdata = 8'hA5;
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 11'h7FF || ram_wdata !== 8'hA5 || host_ack !== 1'b0) begin
      errors++;
      $display("FAIL wr_grant: we=%b addr=%h wd=%h ack=%b, required 1 / 7ff / a5 / 0", ram_we, ram_addr, ram_wdata, host_ack);
    end
    tick();
    checks++;
    if (host_ack !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack: ack=%b we=%b, required 1 / 0", host_ack, ram_we);
    end
    host_req = 1'b0; host_we = 1'b0;
    ref_mem[2047] = 8'hA5;
    tick();
    checks++;
    if (host_ack !== 1'b0 || ram_we !== 1'b0 || mem[2047] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_single_pulse: ack=%b we=%b mem=%h, required 0 / 0 / a5", host_ack, ram_we, mem[2047]);
    end
    idle(2);
  endtask

  task automatic test_host_read();
    ref_mem[16] = 8'h3C;
    load_mem();
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010;
    tick();
    checks++;
    if (ram_addr !== 11'h010 || ram_we !== 1'b0 || host_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: addr=%h we=%b ack=%b, required 010 / 0 / 0", ram_addr, ram_we, host_ack);
    end
    tick();
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_ack: ack=%b, required 0", host_ack);
    end
    tick();
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL rd_data: ack=%b rdata=%h, required 1 / 3c", host_ack, host_rdata);
    end
    host_req = 1'b0;
    tick();
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_single_pulse: ack=%b, required 0", host_ack);
    end
    idle(2);
  endtask

  task automatic test_starve();
    ref_mem[5] = 8'h5A;
    load_mem();
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    disp_req = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      disp_x = 7'($urandom_range(0, 127));
      disp_y = 7'($urandom_range(0, 127));
      tick();
      checks++;
      if (host_starve !== (k >= LIMIT) || ram_we !== 1'b0 ||
          ram_addr !== 11'(addr_f(disp_x, disp_y)) || host_ack !== 1'b0) begin
        errors++;
        $display("FAIL starve_cycle_%0d: starve=%b we=%b addr=%0d ack=%b, required %b / 0 / %0d / 0",
                 k, host_starve, ram_we, ram_addr, host_ack, (k >= LIMIT), addr_f(disp_x, disp_y));
      end
    end
    disp_req = 1'b0;
    tick();
    checks++;
    if (host_starve !== 1'b0 || ram_addr !== 11'd5) begin
      errors++;
      $display("FAIL starve_release: starve=%b addr=%0d, required 0 / 5", host_starve, ram_addr);
    end
    repeat (2) tick();
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL starve_read: ack=%b rdata=%h, required 1 / 5a", host_ack, host_rdata);
    end
    idle(3);
  endtask

  task automatic test_alt_disp_read();
    logic [ADDR_W-1:0] raddr;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    load_mem();
    idle(2);
    for (int p = 0; p < 2; p++) begin
      raddr = (p == 0) ? 11'h040 : 11'h123;
      host_req = 1'b1; host_we = 1'b0; host_addr = raddr;
      disp_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        checks++;
        if (disp_pix_valid !== e2_v || disp_pix !== e2_p) begin
          errors++;
          $display("FAIL alt_pix p%0d c%0d: vld=%b pix=%b, required %b / %b", p, c, disp_pix_valid, disp_pix, e2_v, e2_p);
        end
        checks++;
        if (c == 2) begin
          if (host_ack !== 1'b1 || host_rdata !== ref_mem[raddr]) begin
            errors++;
            $display("FAIL alt_rdata p%0d: ack=%b rdata=%h, required 1 / %h", p, host_ack, host_rdata, ref_mem[raddr]);
          end
          host_req = 1'b0;
        end else if (host_ack !== 1'b0) begin
          errors++;
          $display("FAIL alt_spurious_ack p%0d c%0d: ack=%b, required 0", p, c, host_ack);
        end
        if (c == 0) begin
          checks++;
          if (ram_addr !== raddr) begin
            errors++;
            $display("FAIL alt_grant p%0d: addr=%h, required %h", p, ram_addr, raddr);
          end
        end
        if (disp_req) begin
          checks++;
          if (ram_addr !== 11'(addr_f(disp_x, disp_y)) || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL alt_disp_addr p%0d c%0d: addr=%0d we=%b, required %0d / 0", p, c, ram_addr, ram_we, addr_f(disp_x, disp_y));
          end
        end
        e2_v = e1_v; e2_p = e1_p;
        e1_v = disp_req; e1_p = disp_req ? pix_f(disp_x, disp_y) : 1'b0;
        disp_req = ((c + p) % 2 == 0);
        disp_x = 7'($urandom_range(0, 127));
        disp_y = 7'($urandom_range(0, 127));
      end
      idle(3);
    end
  endtask

  task automatic test_reset_mid_read();
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h020;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_addr !== '0 || ram_we !== 1'b0 || ram_wdata !== '0 || host_ack !== 1'b0 ||
        host_rdata !== '0 || host_starve !== 1'b0 || disp_pix !== 1'b0 || disp_pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: addr=%h we=%b ack=%b rd=%h starve=%b pix=%b vld=%b, required all 0",
               ram_addr, ram_we, host_ack, host_rdata, host_starve, disp_pix, disp_pix_valid);
    end
    host_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (host_ack !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_ack_%0d: ack=%b, required 0", i, host_ack);
      end
    end
    host_req = 1'b1;
    repeat (3) tick();
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== ref_mem[32]) begin
      errors++;
      $display("FAIL midrst_reissue: ack=%b rdata=%h, required 1 / %h", host_ack, host_rdata, ref_mem[32]);
    end
    idle(3);
  endtask

  task automatic test_random();
    bit                outstanding = 1'b0;
    bit                op_we = 1'b0;
    logic [ADDR_W-1:0] op_addr = '0;
    logic [DATA_W-1:0] op_wdata = '0;
    int                waited = 0;
    int                ops_done = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    load_mem();
    idle(2);
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if (disp_pix_valid !== e2_v || disp_pix !== e2_p) begin
        errors++;
        $display("FAIL rnd_pix c%0d: vld=%b pix=%b, required %b / %b", c, disp_pix_valid, disp_pix, e2_v, e2_p);
      end
      if (disp_req) begin
        checks++;
        if (ram_addr !== 11'(addr_f(disp_x, disp_y)) || ram_we !== 1'b0) begin
          errors++;
          $display("FAIL rnd_disp_addr c%0d: addr=%0d we=%b, required %0d / 0", c, ram_addr, ram_we, addr_f(disp_x, disp_y));
        end
      end
      if (host_ack) begin
        checks++;
        if (!outstanding) begin
          errors++;
          $display("FAIL rnd_spurious_ack c%0d: ack=1, required 0", c);
        end else if (!op_we && host_rdata !== ref_mem[op_addr]) begin
          errors++;
          $display("FAIL rnd_rdata c%0d addr=%h: rdata=%h, required %h", c, op_addr, host_rdata, ref_mem[op_addr]);
        end
        if (outstanding && op_we) ref_mem[op_addr] = op_wdata;
        outstanding = 1'b0;
        host_req = 1'b0;
        ops_done++;
      end else if (outstanding) begin
        waited++;
        if (waited > 2000) begin
          checks++;
          errors++;
          $display("FAIL rnd_timeout c%0d: ack never seen, required within 2000 cycles", c);
          outstanding = 1'b0;
          host_req = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 30) begin
        op_we = 1'($urandom);
        op_addr = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 15)) : 11'($urandom);
        op_wdata = 8'($urandom);
        host_req = 1'b1; host_we = op_we; host_addr = op_addr; host_wdata = op_wdata;
        outstanding = 1'b1;
        waited = 0;
      end
      e2_v = e1_v; e2_p = e1_p;
      e1_v = disp_req; e1_p = disp_req ? pix_f(disp_x, disp_y) : 1'b0;
      disp_req = ($urandom_range(0, 99) < 50);
      disp_x = 7'($urandom_range(0, 127));
      disp_y = 7'($urandom_range(0, 127));
    end
    checks++;
    if (ops_done < 100) begin
      errors++;
      $display("FAIL rnd_throughput: ops=%0d, required >= 100", ops_done);
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_disp_fetch();
    test_host_write();
    test_host_read();
    test_starve();
    test_alt_disp_read();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11: bitmap RAM address width (2048 bytes, 128x128 1-bpp).
REQ-002 Parameter DATA_W, default 8: RAM word width; pixels per word.
REQ-003 Parameter STARVE_LIMIT, default 1024: host wait cycles before host_starve asserts.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 disp_req  in  1  display pixel fetch request (pixel window data_valid).
REQ-007 disp_x  in  7  display pixel column 0..127.
REQ-008 disp_y  in  7  display pixel row 0..127.
REQ-009 disp_pix  out  1  fetched pixel value.
REQ-010 disp_pix_valid  out  1  disp_pix qualifier.
REQ-011 host_req  in  1  host access request, held high until host_ack.
REQ-012 host_we  in  1  1 = write, 0 = read; stable while host_req high.
REQ-013 host_addr  in  ADDR_W  host byte address; stable while host_req high.
REQ-014 host_wdata  in  DATA_W  host write data; stable while host_req high.
REQ-015 host_ack  out  1  one-cycle completion pulse.
REQ-016 host_rdata  out  DATA_W  read data, valid in the host_ack cycle of a read.
REQ-017 host_starve  out  1  host waiting >= STARVE_LIMIT cycles.
REQ-018 ram_addr  out  ADDR_W  single-port RAM address.
REQ-019 ram_we  out  1  RAM write enable.
REQ-020 ram_wdata  out  DATA_W  RAM write data.
REQ-021 ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr.

Function
REQ-022 Display fetch SHALL have absolute priority; display is never stalled or dropped.
REQ-023 Display address SHALL be disp_y*16 + disp_x[6:3], computed in ADDR_W bits (max 2047, no overflow).
REQ-024 disp_req sampled at edge N SHALL drive registered ram_addr from edge N, ram_we=0; disp_pix/disp_pix_valid registered at edge N+2 (latency 2).
REQ-025 disp_pix SHALL be ram_rdata[7 - disp_x[2:0]] (MSB = leftmost pixel); bit index delayed two stages to align with RAM latency.
REQ-026 disp_pix_valid SHALL be disp_req delayed two cycles; disp_pix = 0 when not valid.
REQ-027 Host granted at an edge where host_req=1, disp_req=0, FSM in H_IDLE.
REQ-028 Host FSM states: H_IDLE, H_RD_WAIT, H_RD_CAP. Write grant: ram_we=1 for one cycle, host_ack pulse at next edge, stay H_IDLE.
REQ-029 Read grant -> H_RD_WAIT (RAM access) -> H_RD_CAP (capture ram_rdata into host_rdata, host_ack pulse) -> H_IDLE.
REQ-030 Display requests arriving during H_RD_WAIT/H_RD_CAP SHALL still win the RAM port; host read data captured from the pipeline slot of its own grant only.
REQ-031 After host_ack, a new host grant SHALL not occur in the same cycle the ack is high (host_req deassert time).
REQ-032 Idle RAM port: ram_we=0, ram_addr holds last value.
REQ-033 Wait counter: increments each cycle host_req=1 and not granted, saturates at STARVE_LIMIT, clears on grant; host_starve = (count == STARVE_LIMIT).
REQ-034 Simultaneous disp_req and host_req: display served, host waits, counter increments.

Reset
REQ-035 On rst_n low all outputs and state clear immediately: ram_addr=0, ram_we=0, ram_wdata=0, disp_pix=0, disp_pix_valid=0, host_ack=0, host_rdata=0, host_starve=0, FSM=H_IDLE, pipeline stages 0.
REQ-036 Reset mid-operation drops any in-flight host access with no host_ack; host re-issues.

Structure
REQ-037 Shared package holds host FSM state encoding and ADDR_W/DATA_W defaults.
REQ-038 One sub-module, vram_disp_fetch: address compute and 2-stage bit-index/valid pipeline.

Verification
REQ-039 disp_req=1, x=9, y=2 -> ram_addr=33 next cycle; with ram_rdata=8'b0100_0000, disp_pix=1, valid 2 cycles after sample.
REQ-040 disp_req=0, host write addr=0x7FF data=0xA5 -> ram_we=1 one cycle, ram_addr=0x7FF, host_ack one pulse.
REQ-041 Host read addr=0x010 with RAM holding 0x3C -> host_ack with host_rdata=0x3C in H_RD_CAP cycle.
REQ-042 disp_req held high 1100 cycles with host_req high -> no grant, host_starve=1 from cycle 1024; grant on first disp_req=0 cycle, host_starve clears.
REQ-043 Alternating disp_req 1/0 during host read -> display pixels correct, host_rdata correct.
REQ-044 rst_n asserted in H_RD_WAIT -> no host_ack, all outputs 0, FSM H_IDLE.
